// File: rtl/char_feeder_pkg.sv
// Shared ASCII constants and case-folding helper for the character feeder and scorer.
package char_feeder_pkg;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_A_UP  = 8'h41;
    localparam logic [7:0] CH_Z_UP  = 8'h5A;
    localparam logic [7:0] CASE_OFS = 8'h20;

    function automatic logic [7:0] fold_char(input logic [7:0] c);
        if (c >= CH_A_UP && c <= CH_Z_UP)
            return c + CASE_OFS;
        return c;
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Byte FIFO: storage, wrapping pointers and occupancy count.
module char_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 wdata,
    output logic [7:0]                 rdata,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign rdata = mem[rptr];

    // Contents are deliberately left uncleared by reset; level alone marks validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/char_feeder.sv
// Buffers producer bytes and emits one registered character per cycle to the scorer.
module char_feeder
    import char_feeder_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] IDLE_CHAR = CH_SPACE,
    parameter bit         FOLD      = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [7:0]                 char,
    output logic                       char_vld,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic       push;
    logic       pop;
    logic [7:0] head;

    assign in_ready = level < LVL_FULL;
    assign push     = in_valid && in_ready;
    assign pop      = level != '0;

    char_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .level (level)
    );

    // Head is only consumed when already buffered, so a push into an empty FIFO never bypasses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            char     <= IDLE_CHAR;
            char_vld <= 1'b0;
        end else if (pop) begin
            char     <= FOLD ? fold_char(head) : head;
            char_vld <= 1'b1;
        end else begin
            char     <= IDLE_CHAR;
            char_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_char_feeder.sv
// Directed vector bench for char_feeder: plain and case-folding instances driven in parallel.
module tb_char_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;

    logic       rdy,  vld,  frdy, fvld;
    logic [7:0] ch,   fch;
    logic [3:0] lvl,  flvl;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    char_feeder #(.DEPTH(8), .IDLE_CHAR(8'h20), .FOLD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy), .char(ch), .char_vld(vld), .level(lvl)
    );

    char_feeder #(.DEPTH(8), .IDLE_CHAR(8'h20), .FOLD(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(frdy), .char(fch), .char_vld(fvld), .level(flvl)
    );

    typedef struct {
        logic       rst_n;
        logic       vin;
        logic [7:0] din;
        logic [7:0] ech;
        logic [7:0] efch;
        logic       evld;
        logic [3:0] elvl;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic r, input logic v, input logic [7:0] d,
                        input logic [7:0] e, input logic [7:0] ef, input logic ev,
                        input logic [3:0] el);
        vec_t t;
        t.rst_n = r; t.vin = v; t.din = d;
        t.ech = e; t.efch = ef; t.evld = ev; t.elvl = el;
        tv.push_back(t);
    endtask

    task automatic drive_edge(input logic r, input logic v, input logic [7:0] d);
        rst_n    = r;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] ex;
        logic       ev;
        int         sent;
        int         cyc;
        logic       v;
        logic [7:0] d;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        // Reset overriding a push, then 5 idle cycles
        addv(0, 1, "X", 8'h20, 8'h20, 0, 0);
        for (int unsigned i = 0; i < 5; i++) addv(1, 0, 8'h00, 8'h20, 8'h20, 0, 0);
        // "CSCORE"
        addv(1, 1, "C", 8'h20, 8'h20, 0, 1);
        addv(1, 1, "S", "C", "c", 1, 1);
        addv(1, 1, "C", "S", "s", 1, 1);
        addv(1, 1, "O", "C", "c", 1, 1);
        addv(1, 1, "R", "O", "o", 1, 1);
        addv(1, 1, "E", "R", "r", 1, 1);
        addv(1, 0, 8'h00, "E", "e", 1, 0);
        addv(1, 0, 8'h00, 8'h20, 8'h20, 0, 0);
        // "CsCoRe!"
        addv(1, 1, "C", 8'h20, 8'h20, 0, 1);
        addv(1, 1, "s", "C", "c", 1, 1);
        addv(1, 1, "C", "s", "s", 1, 1);
        addv(1, 1, "o", "C", "c", 1, 1);
        addv(1, 1, "R", "o", "o", 1, 1);
        addv(1, 1, "e", "R", "r", 1, 1);
        addv(1, 1, "!", "e", "e", 1, 1);
        addv(1, 0, 8'h00, "!", "!", 1, 0);
        addv(1, 0, 8'h00, 8'h20, 8'h20, 0, 0);
        // Fold range boundaries: '@' 'A' 'Z' '['
        addv(1, 1, "@", 8'h20, 8'h20, 0, 1);
        addv(1, 1, "A", "@", "@", 1, 1);
        addv(1, 1, "Z", "A", "a", 1, 1);
        addv(1, 1, "[", "Z", "z", 1, 1);
        addv(1, 0, 8'h00, "[", "[", 1, 0);
        addv(1, 0, 8'h00, 8'h20, 8'h20, 0, 0);
        // Fill, then reset with a same-edge push; buffered byte must be discarded
        addv(1, 1, "1", 8'h20, 8'h20, 0, 1);
        addv(1, 1, "2", "1", "1", 1, 1);
        addv(1, 1, "3", "2", "2", 1, 1);
        addv(1, 1, "4", "3", "3", 1, 1);
        addv(1, 1, "5", "4", "4", 1, 1);
        addv(0, 1, "6", 8'h20, 8'h20, 0, 0);
        addv(1, 0, 8'h00, 8'h20, 8'h20, 0, 0);
        addv(1, 0, 8'h00, 8'h20, 8'h20, 0, 0);

        foreach (tv[i]) begin
            drive_edge(tv[i].rst_n, tv[i].vin, tv[i].din);
            chk($sformatf("vec%0d char", i), 32'(ch), 32'(tv[i].ech));
            chk($sformatf("vec%0d fold_char", i), 32'(fch), 32'(tv[i].efch));
            chk($sformatf("vec%0d char_vld", i), 32'(vld), 32'(tv[i].evld));
            chk($sformatf("vec%0d fold_vld", i), 32'(fvld), 32'(tv[i].evld));
            chk($sformatf("vec%0d level", i), 32'(lvl), 32'(tv[i].elvl));
            chk($sformatf("vec%0d in_ready", i), 32'(rdy), 32'd1);
            chk($sformatf("vec%0d fold_ready", i), 32'(frdy), 32'd1);
        end

        // Continuous stream 0x30..0x43: each byte emerges one edge after acceptance
        for (int i = 0; i < 20; i++) begin
            drive_edge(1, 1, 8'(8'h30 + i));
            chk($sformatf("stream%0d char", i), 32'(ch), (i == 0) ? 32'h20 : 32'(8'h30 + i - 1));
            chk($sformatf("stream%0d vld", i), 32'(vld), (i == 0) ? 32'd0 : 32'd1);
            chk($sformatf("stream%0d level", i), 32'(lvl), 32'd1);
            chk($sformatf("stream%0d in_ready", i), 32'(rdy), 32'd1);
        end
        drive_edge(1, 0, 8'h00);
        chk("stream_tail char", 32'(ch), 32'h43);
        chk("stream_tail level", 32'(lvl), 32'd0);
        drive_edge(1, 0, 8'h00);
        chk("stream_idle vld", 32'(vld), 32'd0);

        // Pointer wrap with random gaps against a queue scoreboard
        sent = 0;
        cyc  = 0;
        while ((sent < 27 || q.size() != 0) && cyc < 500) begin
            v = (sent < 27) && ($urandom_range(0, 2) != 0);
            d = 8'($urandom);
            drive_edge(1, v, d);
            cyc++;
            if (q.size() > 0) begin
                ex = q.pop_front();
                ev = 1'b1;
            end else begin
                ex = 8'h20;
                ev = 1'b0;
            end
            if (v) begin
                q.push_back(d);
                sent++;
            end
            chk($sformatf("wrap%0d char", cyc), 32'(ch), 32'(ex));
            chk($sformatf("wrap%0d vld", cyc), 32'(vld), 32'(ev));
            chk($sformatf("wrap%0d level", cyc), 32'(lvl), 32'(q.size()));
            chk($sformatf("wrap%0d level_bound", cyc), 32'(lvl <= 4'd8), 32'd1);
        end
        chk("wrap_completed", 32'(cyc < 500), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
